disp_scan_mux: RTL and testbench



---
 rtl/disp_scan_mux.sv | 97 +++++++++
 tb/tb_disp_scan_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux.sv
// Multiplexed 7-segment scanner: double-buffered nibble store, one digit slot per PRESCALE clocks.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan_mux #(
   parameter int NDIGITS  = 4,
   parameter int PRESCALE = 1000,
   parameter int DEADTIME = 2
) (
   input  logic                   Clk,
   input  logic                   nReset,
   input  logic [4*NDIGITS-1:0]   DataIn,
   input  logic                   Load,
   input  logic                   Enable,
   output logic [3:0]             BinOut,
   output logic                   Oe,
   output logic [NDIGITS-1:0]     DigSel,
   output logic                   FrameEnd
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(NDIGITS);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

   logic [PW-1:0]          r_pre;
   logic [IW-1:0]          r_idx;
   logic [4*NDIGITS-1:0]   r_pend;
   logic [4*NDIGITS-1:0]   r_disp;
   logic                   r_pend_vld;

   logic w_run;
   logic w_slot_end;
   logic w_wrap;
   logic w_lit_cur;

   // Gating with nReset keeps the display dark while reset is held, even if Enable is high.
   assign w_run      = Enable & nReset;
   assign w_slot_end = (r_pre == PRE_LAST);
   assign w_wrap     = w_run & w_slot_end & (r_idx == IDX_LAST);

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_pre      <= '0;
         r_idx      <= '0;
         r_pend     <= '0;
         r_disp     <= '0;
         r_pend_vld <= 1'b0;
      end else begin
         if (Enable) begin
            if (w_slot_end) begin
               r_pre <= '0;
               r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
               r_pre <= r_pre + 1'b1;
            end
         end

         if (Load)
            r_pend <= DataIn;

         // A Load landing on the wrap edge bypasses the pending buffer entirely.
         if (w_wrap && Load) begin
            r_disp     <= DataIn;
            r_pend_vld <= 1'b0;
         end else if (w_wrap && r_pend_vld) begin
            r_disp     <= r_pend;
            r_pend_vld <= 1'b0;
         end else if (Load) begin
            r_pend_vld <= 1'b1;
         end
      end
   end

`ifdef DISP_SCAN_LZB_EN
   logic [NDIGITS-1:0] w_lit;

   // Digit k is lit if any nibble at position k or above is nonzero; digit 0 always lit.
   always_comb begin
      logic acc;
      acc   = 1'b0;
      w_lit = '0;
      for (int k = NDIGITS - 1; k > 0; k--) begin
         acc      = acc | (|r_disp[4*k +: 4]);
         w_lit[k] = acc;
      end
      w_lit[0] = 1'b1;
   end

   assign w_lit_cur = w_lit[r_idx];
`else
   assign w_lit_cur = 1'b1;
`endif

   assign BinOut   = r_disp[{r_idx, 2'b00} +: 4];
   assign DigSel   = w_run ? ({{(NDIGITS-1){1'b0}}, 1'b1} << r_idx) : '0;
   assign Oe       = w_run & (int'(r_pre) >= DEADTIME) & w_lit_cur;
   assign FrameEnd = w_wrap;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboarded random test of disp_scan_mux against a frame-level reference model,
// plus a long-prescale instance for frame period and Oe duty.
module tb_disp_scan_mux;
   localparam int N = 4;
   localparam int P = 4;
   localparam int D = 1;

   logic        Clk = 1'b0;
   bit          clk_run = 1'b1;
   logic        nReset;
   logic [15:0] DataIn;
   logic        Load;
   logic        Enable;
   logic [3:0]  BinOut;
   logic        Oe;
   logic [3:0]  DigSel;
   logic        FrameEnd;

   logic        Clk2 = 1'b0;
   logic        nReset2;
   logic [15:0] DataIn2;
   logic        Load2;
   logic        Enable2;
   logic [3:0]  BinOut2;
   logic        Oe2;
   logic [3:0]  DigSel2;
   logic        FrameEnd2;

   int n_chk  = 0;
   int n_pass = 0;
   bit big_done = 1'b0;

   logic [9:0] expq[$];

   // reference model: enabled-cycle count gives slot position, plus display/pending values
   longint      m_n;
   logic [15:0] m_disp, m_pend;
   bit          m_pv;

   disp_scan_mux #(.NDIGITS(N), .PRESCALE(P), .DEADTIME(D)) u_dut (
      .Clk(Clk), .nReset(nReset), .DataIn(DataIn), .Load(Load), .Enable(Enable),
      .BinOut(BinOut), .Oe(Oe), .DigSel(DigSel), .FrameEnd(FrameEnd)
   );

   disp_scan_mux #(.NDIGITS(4), .PRESCALE(1000), .DEADTIME(2)) u_big (
      .Clk(Clk2), .nReset(nReset2), .DataIn(DataIn2), .Load(Load2), .Enable(Enable2),
      .BinOut(BinOut2), .Oe(Oe2), .DigSel(DigSel2), .FrameEnd(FrameEnd2)
   );

   always #5 if (clk_run) Clk = ~Clk;
   always #5 Clk2 = ~Clk2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int m_idx();
      return int'((m_n / P) % N);
   endfunction

   function automatic int m_pre();
      return int'(m_n % P);
   endfunction

   function automatic bit m_lit(input int k);
`ifdef DISP_SCAN_LZB_EN
      return (k == 0) || ((m_disp >> (4*k)) != 16'h0);
`else
      return (k >= 0);
`endif
   endfunction

   task automatic m_reset();
      m_n = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
   endtask

   // Apply inputs for one cycle, queue the expected outputs, advance the model over the next edge.
   task automatic tick(input bit ld, input logic [15:0] din, input bit en);
      int idx, pre;
      bit fe;
      logic [9:0] e;
      Load = ld; DataIn = din; Enable = en;
      idx = m_idx(); pre = m_pre();
      fe  = en && idx == N-1 && pre == P-1;
      e[9:6] = 4'((m_disp >> (4*idx)) & 16'hF);
      e[5]   = en && pre >= D && m_lit(idx);
      e[4:1] = en ? 4'(1 << idx) : 4'b0;
      e[0]   = fe;
      expq.push_back(e);
      if (fe && ld) begin
         m_disp = din; m_pv = 1'b0;
      end else if (fe && m_pv) begin
         m_disp = m_pend; m_pv = 1'b0;
      end else if (ld) begin
         m_pend = din; m_pv = 1'b1;
      end
      if (en) m_n++;
      @(posedge Clk); #1;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) tick(1'b0, 16'h0, 1'b1);
   endtask

   task automatic run_until(input int idx, input int pre);
      int guard = 0;
      while (!(m_idx() == idx && m_pre() == pre) && guard < 64) begin
         tick(1'b0, 16'h0, 1'b1);
         guard++;
      end
      chk("reach_slot_pos", 32'(m_idx() == idx && m_pre() == pre), 32'd1);
   endtask

   // Stop the clock low, pulse reset with no edges, check outputs go dark asynchronously.
   task automatic mid_reset();
      @(negedge Clk); #1;
      clk_run = 1'b0;
      #2 nReset = 1'b0;
      #1 chk("rst_async", 32'({BinOut, Oe, DigSel, FrameEnd}), 32'd0);
      #30 chk("rst_hold", 32'({BinOut, Oe, DigSel, FrameEnd}), 32'd0);
      Enable = 1'b0; Load = 1'b0;
      nReset = 1'b1;
      m_reset();
      #2 clk_run = 1'b1;
      @(posedge Clk); #1;
   endtask

   always @(negedge Clk) begin
      if (expq.size() != 0) begin
         logic [9:0] e;
         e = expq.pop_front();
         chk("outs{bin,oe,sel,fe}", 32'({BinOut, Oe, DigSel, FrameEnd}), 32'(e));
      end
   end

   // Long-prescale instance: FrameEnd period and Oe duty over one full frame.
   initial begin
      int cyc = 0, c1 = -1, c2 = -1, oe_cnt = 0;
      nReset2 = 1'b0; Enable2 = 1'b1; Load2 = 1'b0; DataIn2 = 16'h1234;
      #23 nReset2 = 1'b1; Load2 = 1'b1;
      @(posedge Clk2); #1 Load2 = 1'b0;
      while (c2 < 0 && cyc < 10000) begin
         @(negedge Clk2);
         cyc++;
         if (c1 >= 0) oe_cnt += int'(Oe2);
         if (FrameEnd2) begin
            if (c1 < 0) c1 = cyc;
            else        c2 = cyc;
         end
      end
      chk("big_frame_seen", 32'(c2 >= 0), 32'd1);
      chk("big_frame_period", 32'(c2 - c1), 32'd4000);
      chk("big_oe_high_cycles", 32'(oe_cnt), 32'd3992);
      @(negedge Clk2);
      chk("big_frameend_width", 32'(FrameEnd2), 32'd0);
      big_done = 1'b1;
   end

   initial begin
      nReset = 1'b0; Enable = 1'b0; Load = 1'b0; DataIn = '0;
      m_reset();
      #12 chk("reset_state", 32'({BinOut, Oe, DigSel, FrameEnd}), 32'd0);
      #4 nReset = 1'b1;
      @(posedge Clk); #1;

      // free run, then a mid-scan reset after a load so BinOut was nonzero
      run(6);
      tick(1'b1, 16'h9ABC, 1'b1);
      run(20);
      tick(1'b1, 16'h1111, 1'b1);
      run(3);
      mid_reset();
      run(10);

      // double-buffered load mid-slot of digit 1
      run_until(1, 1);
      tick(1'b1, 16'h4321, 1'b1);
      run(2 * N * P);

      // older pending discarded by a load on the FrameEnd cycle
      tick(1'b1, 16'hAAAA, 1'b1);
      run_until(N-1, P-1);
      tick(1'b1, 16'h5678, 1'b1);
      run(N * P + 4);

      // enable freeze at Idx=2, PreCnt=1
      run_until(2, 1);
      for (int i = 0; i < 10; i++) tick(1'b0, 16'h0, 1'b0);
      run(N * P);

      // blanking patterns
      tick(1'b1, 16'h0050, 1'b1);
      run(2 * N * P);
      tick(1'b1, 16'h0000, 1'b1);
      run(2 * N * P);
      tick(1'b1, 16'h0300, 1'b0);
      run(2 * N * P);

      for (int i = 0; i < 1500; i++) begin
         bit en, ld;
         logic [15:0] din;
         en  = ($urandom_range(0, 9) != 0);
         ld  = ($urandom_range(0, 7) == 0);
         din = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         tick(ld, din, en);
         if (i == 700) mid_reset();
      end
      tick(1'b0, 16'h0, 1'b1);

      for (int i = 0; i < 20000 && !big_done; i++) @(posedge Clk2);
      chk("big_done", 32'(big_done), 32'd1);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
